prbs_checker: RTL and testbench

PRBS_CHECKER -- requirements
Module: prbs_checker

---
 rtl/prbs_pkg.sv | 15 +
 rtl/prbs_sat_cnt.sv | 22 ++
 rtl/prbs_checker.sv | 133 +++++++++++++
 tb/tb_prbs_checker.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prbs_pkg.sv
// PRBS checker shared types: FSM state codes and default parameters.
package prbs_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam int N_DEF     = 4;
    localparam int LOCK_DEF  = 4;
    localparam int LOSS_DEF  = 3;
    localparam int CNT_W_DEF = 16;

endpackage

// File: rtl/prbs_sat_cnt.sv
// Saturating up-counter with synchronous clear that wins over increment.
module prbs_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && cnt != '1) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/prbs_checker.sv
// PRBS state-word checker: hunt, sync, locked flywheel with loss detection.
// Error counter is built only when PRBS_CHK_ERRCNT_EN is defined.
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int N        = N_DEF,
    parameter int LOCK_CNT = LOCK_DEF,
    parameter int LOSS_CNT = LOSS_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [N-1:0]     in_data,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err,
    output logic             zero_err,
    output logic [CNT_W-1:0] err_cnt,
    output logic [1:0]       state
);

    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int BW = $clog2(LOSS_CNT + 1);
    localparam logic [GW-1:0] LOCK_M1 = GW'(LOCK_CNT - 1);
    localparam logic [BW-1:0] LOSS_M1 = BW'(LOSS_CNT - 1);

    function automatic logic [N-1:0] nxt(input logic [N-1:0] x);
        return {x[0] ^ x[N-3] ^ x[N-2], x[N-1:1]};
    endfunction

    state_t        st_q, st_d;
    logic [N-1:0]  exp_q, exp_d;
    logic [GW-1:0] good_q, good_d;
    logic [BW-1:0] bad_q, bad_d;
    logic          locked_d, err_d, zero_d;
    logic          match;

    assign match = (in_data == exp_q);
    assign state = st_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) st_q <= HUNT;
        else      st_q <= st_d;
    end

    always_comb begin
        st_d = st_q;
        case (st_q)
            HUNT:
                if (in_valid && in_data != '0) st_d = SYNC;
            SYNC:
                if (in_valid && match && good_q == LOCK_M1) st_d = LOCKED;
            LOCKED:
                if (in_valid && !match && bad_q == LOSS_M1) st_d = HUNT;
            default:
                st_d = HUNT;
        endcase
    end

    always_comb begin
        locked_d = (st_d == LOCKED);
        err_d    = in_valid && (st_q == LOCKED) && !match;
        zero_d   = in_valid && (st_q == HUNT) && (in_data == '0);
    end

    // Expected word and run-length counters
    always_comb begin
        exp_d  = exp_q;
        good_d = good_q;
        bad_d  = bad_q;
        case (st_q)
            HUNT:
                if (in_valid && in_data != '0) begin
                    exp_d  = nxt(in_data);
                    good_d = '0;
                    bad_d  = '0;
                end
            SYNC:
                if (in_valid) begin
                    exp_d  = nxt(in_data);
                    good_d = match ? good_q + GW'(1) : '0;
                    bad_d  = '0;
                end
            LOCKED:
                if (in_valid) begin
                    exp_d = nxt(exp_q);
                    if (match || st_d == HUNT) bad_d = '0;
                    else                      bad_d = bad_q + BW'(1);
                end
            default: begin
                exp_d  = '0;
                good_d = '0;
                bad_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp_q    <= '0;
            good_q   <= '0;
            bad_q    <= '0;
            locked   <= 1'b0;
            err      <= 1'b0;
            zero_err <= 1'b0;
        end else begin
            exp_q    <= exp_d;
            good_q   <= good_d;
            bad_q    <= bad_d;
            locked   <= locked_d;
            err      <= err_d;
            zero_err <= zero_d;
        end
    end

`ifdef PRBS_CHK_ERRCNT_EN
    prbs_sat_cnt #(
        .W(CNT_W)
    ) u_cnt (
        .clk(clk),
        .rst(rst),
        .clr(clr_cnt),
        .inc(err_d),
        .cnt(err_cnt)
    );
`else
    logic unused_clr;
    assign unused_clr = clr_cnt;
    assign err_cnt    = '0;
`endif

endmodule

// File: tb/tb_prbs_checker.sv
// Self-checking bench for prbs_checker (N=4) with directed and random tests.
module tb_prbs_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [3:0]  in_data;
    logic        clr_cnt;
    logic        locked;
    logic        err;
    logic        zero_err;
    logic [15:0] err_cnt;
    logic [1:0]  state;

    int tests = 0;
    int fails = 0;
    int ecnt  = 0;
    int cur   = 1;

    prbs_checker dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_data(in_data),
        .clr_cnt(clr_cnt),
        .locked(locked),
        .err(err),
        .zero_err(zero_err),
        .err_cnt(err_cnt),
        .state(state)
    );

    always #5 clk = ~clk;

    function automatic int nx(input int x);
        int fb;
        fb = (x ^ (x >> 1) ^ (x >> 2)) & 1;
        return ((x >> 1) | (fb << 3)) & 15;
    endfunction

    function automatic int cnt_exp(input int c);
`ifdef PRBS_CHK_ERRCNT_EN
        return c;
`else
        return 0 * c;
`endif
    endfunction

    task automatic send(input logic v, input int d);
        in_valid = v;
        in_data  = 4'(d);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0; in_valid = 1'b0; in_data = '0; clr_cnt = 1'b0;
        #2;
        tests++;
        if (state !== 2'd0 || locked !== 1'b0 || err_cnt !== 16'd0) begin
            fails++;
            $display("FAIL reset_async: state=%0h locked=%0h cnt=%0h want 0 0 0",
                     state, locked, err_cnt);
        end
        tests++;
        if (err !== 1'b0 || zero_err !== 1'b0) begin
            fails++;
            $display("FAIL reset_pulses: err=%0h zero=%0h want 0 0", err, zero_err);
        end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic lock_up(input string tag, input int seed);
        cur = seed;
        for (int i = 1; i <= 5; i++) begin
            send(1'b1, cur);
            cur = nx(cur);
            if (i == 4) begin
                tests++;
                if (locked !== 1'b0 || state !== 2'd1) begin
                    fails++;
                    $display("FAIL %s_4th: locked=%0h state=%0h want 0 1", tag, locked, state);
                end
            end
        end
        tests++;
        if (locked !== 1'b1 || state !== 2'd2) begin
            fails++;
            $display("FAIL %s_5th: locked=%0h state=%0h want 1 2", tag, locked, state);
        end
    endtask

    task automatic test_lock;
        lock_up("lock", 1);
        tests++;
        if (err_cnt !== 16'(cnt_exp(ecnt))) begin
            fails++;
            $display("FAIL lock_cnt: got %0d want %0d", err_cnt, cnt_exp(ecnt));
        end
    endtask

    task automatic test_single_error;
        send(1'b1, cur ^ 2);
        cur = nx(cur);
        ecnt++;
        tests++;
        if (err !== 1'b1 || locked !== 1'b1 || err_cnt !== 16'(cnt_exp(ecnt))) begin
            fails++;
            $display("FAIL single_err: err=%0h locked=%0h cnt=%0d want 1 1 %0d",
                     err, locked, err_cnt, cnt_exp(ecnt));
        end
        for (int i = 0; i < 3; i++) begin
            send(1'b1, cur);
            cur = nx(cur);
            tests++;
            if (err !== 1'b0 || locked !== 1'b1 || err_cnt !== 16'(cnt_exp(ecnt))) begin
                fails++;
                $display("FAIL single_after%0d: err=%0h locked=%0h cnt=%0d want 0 1 %0d",
                         i, err, locked, err_cnt, cnt_exp(ecnt));
            end
        end
    endtask

    task automatic test_loss;
        for (int i = 1; i <= 3; i++) begin
            send(1'b1, cur ^ 8);
            cur = nx(cur);
            ecnt++;
            tests++;
            if (err !== 1'b1 || err_cnt !== 16'(cnt_exp(ecnt))) begin
                fails++;
                $display("FAIL loss_err%0d: err=%0h cnt=%0d want 1 %0d",
                         i, err, err_cnt, cnt_exp(ecnt));
            end
            tests++;
            if (locked !== (i < 3) || state !== ((i < 3) ? 2'd2 : 2'd0)) begin
                fails++;
                $display("FAIL loss_state%0d: locked=%0h state=%0h want %0h %0h",
                         i, locked, state, (i < 3), (i < 3) ? 2 : 0);
            end
        end
    endtask

    task automatic test_zero_gap;
        int n;
        send(1'b1, 0);
        tests++;
        if (zero_err !== 1'b1 || state !== 2'd0 || err !== 1'b0) begin
            fails++;
            $display("FAIL zero_pulse: zero=%0h state=%0h err=%0h want 1 0 0",
                     zero_err, state, err);
        end
        send(1'b0, 0);
        tests++;
        if (zero_err !== 1'b0 || state !== 2'd0) begin
            fails++;
            $display("FAIL zero_drop: zero=%0h state=%0h want 0 0", zero_err, state);
        end
        cur = $urandom_range(15, 1);
        n = 0;
        while (n < 5) begin
            send(1'b1, cur);
            cur = nx(cur);
            n++;
            for (int g = 0; g < int'($urandom_range(2, 1)); g++) begin
                send(1'b0, $urandom % 16);
                tests++;
                if (locked !== (n == 5) || zero_err !== 1'b0 || err !== 1'b0) begin
                    fails++;
                    $display("FAIL gap_v%0d: locked=%0h zero=%0h err=%0h want %0h 0 0",
                             n, locked, zero_err, err, (n == 5));
                end
            end
        end
        tests++;
        if (state !== 2'd2) begin
            fails++;
            $display("FAIL gap_lock: state=%0h want 2", state);
        end
    endtask

    task automatic test_clear;
        clr_cnt = 1'b1;
        send(1'b1, cur ^ 1);
        cur = nx(cur);
        clr_cnt = 1'b0;
        ecnt = 0;
        tests++;
        if (err !== 1'b1 || err_cnt !== 16'd0) begin
            fails++;
            $display("FAIL clr_prio: err=%0h cnt=%0d want 1 0", err, err_cnt);
        end
        send(1'b1, cur);
        cur = nx(cur);
        send(1'b1, cur ^ 4);
        cur = nx(cur);
        ecnt++;
        tests++;
        if (err_cnt !== 16'(cnt_exp(ecnt)) || locked !== 1'b1) begin
            fails++;
            $display("FAIL clr_recount: cnt=%0d locked=%0h want %0d 1",
                     err_cnt, locked, cnt_exp(ecnt));
        end
        #2 rst = 1'b0;
        #1;
        ecnt = 0;
        tests++;
        if (state !== 2'd0 || locked !== 1'b0 || err_cnt !== 16'd0) begin
            fails++;
            $display("FAIL rst_mid: state=%0h locked=%0h cnt=%0d want 0 0 0",
                     state, locked, err_cnt);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        lock_up("relock", 5);
    endtask

    task automatic test_random;
        int m_mode, m_exp, m_good, m_bad, m_cnt, g, d, r, burst;
        logic v, c, e_err, e_zero;
        int nerr;
        rst = 1'b0;
        #1;
        @(posedge clk); #1;
        rst = 1'b1;
        m_mode = 0; m_exp = 0; m_good = 0; m_bad = 0; m_cnt = 0;
        g = 1; burst = 0; nerr = 0;
        for (int i = 0; i < 800; i++) begin
            v = ($urandom % 4) != 0;
            c = ($urandom % 40) == 0;
            r = $urandom % 32;
            if (v) begin
                g = nx(g);
                d = g;
                if (burst > 0) begin
                    d = g ^ 9; burst--;
                end else if (r == 0) d = 0;
                else if (r < 3) d = g ^ (1 << ($urandom % 4));
                else if (r == 3) burst = 3;
            end else begin
                d = $urandom % 16;
            end
            e_err = 1'b0;
            e_zero = 1'b0;
            if (v) begin
                if (m_mode == 0) begin
                    if (d == 0) e_zero = 1'b1;
                    else begin
                        m_exp = nx(d); m_good = 0; m_mode = 1;
                    end
                end else if (m_mode == 1) begin
                    if (d == m_exp) begin
                        m_good++;
                        if (m_good == 4) begin
                            m_mode = 2; m_bad = 0;
                        end
                    end else m_good = 0;
                    m_exp = nx(d);
                end else begin
                    if (d != m_exp) begin
                        e_err = 1'b1;
                        if (m_cnt < 65535) m_cnt++;
                        m_bad++;
                        if (m_bad == 3) begin
                            m_mode = 0; m_bad = 0;
                        end
                    end else m_bad = 0;
                    m_exp = nx(m_exp);
                end
            end
            if (c) m_cnt = 0;
            if (e_err) nerr++;
            clr_cnt = c;
            send(v, d);
            tests++;
            if (locked !== (m_mode == 2) || err !== e_err || zero_err !== e_zero ||
                state !== 2'(m_mode) || err_cnt !== 16'(cnt_exp(m_cnt))) begin
                fails++;
                $display("FAIL rand%0d: lk=%0h er=%0h zr=%0h st=%0h cnt=%0d want %0h %0h %0h %0h %0d",
                         i, locked, err, zero_err, state, err_cnt,
                         (m_mode == 2), e_err, e_zero, m_mode, cnt_exp(m_cnt));
            end
        end
        clr_cnt = 1'b0;
        tests++;
        if (nerr == 0) begin
            fails++;
            $display("FAIL rand_cov: got %0d err events want >0", nerr);
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_single_error();
        test_loss();
        test_zero_gap();
        test_clear();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
